// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: ROM port, redirect input and the decode-side instruction handshake.
// master = fetch unit, slave = ROM/decode environment.
interface inst_fetch_if;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  modport master (
    output rom_addr, rom_en, inst_valid, inst, inst_pc, halted, fault,
    input  rom_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  rom_addr, rom_en, inst_valid, inst, inst_pc, halted, fault,
    output rom_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: pc register, 2-entry {pc, word} FIFO toward decode, RUN/HALT control
// with ebreak and fault stops, redirect flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 4096
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [32:0] ROM_LIMIT = 33'(ROM_BYTES);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [31:0] r_head_pc;
  logic [31:0] r_head_word;
  logic [31:0] r_tail_pc;
  logic [31:0] r_tail_word;
  logic        r_fault;

  logic w_in_range;
  logic w_aligned;
  logic w_pop;
  logic w_push;

  // 33-bit sum so a pc near 2^32 cannot wrap into the legal range.
  assign w_in_range = ({1'b0, r_pc} + 33'd3) < ROM_LIMIT;
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_pop      = (r_count != 2'd0) && bus.inst_ready;
  assign w_push     = !rst && (r_state == StRun) && w_in_range && w_aligned &&
                      ((r_count != 2'd2) || w_pop);

  assign bus.rom_addr   = r_pc;
  assign bus.rom_en     = w_push;
  assign bus.inst_valid = (r_count != 2'd0);
  assign bus.inst       = r_head_word;
  assign bus.inst_pc    = r_head_pc;
  assign bus.halted     = (r_state == StHalt);
  assign bus.fault      = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_pc        <= RESET_PC;
      r_count     <= 2'd0;
      r_head_pc   <= 32'd0;
      r_head_word <= 32'd0;
      r_tail_pc   <= 32'd0;
      r_tail_word <= 32'd0;
      r_fault     <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_count <= 2'd0;
      r_pc    <= bus.redirect_pc;
      r_state <= StRun;
      r_fault <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_pc   <= r_pc;
            r_head_word <= bus.rom_data;
          end else begin
            r_tail_pc   <= r_pc;
            r_tail_word <= bus.rom_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_pc   <= r_tail_pc;
          r_head_word <= r_tail_word;
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_pc   <= r_pc;
            r_head_word <= bus.rom_data;
          end else begin
            r_head_pc   <= r_tail_pc;
            r_head_word <= r_tail_word;
            r_tail_pc   <= r_pc;
            r_tail_word <= bus.rom_data;
          end
        end
        default: ;
      endcase

      if (w_push) begin
        r_pc <= r_pc + 32'd4;
        if (bus.rom_data == EBREAK) r_state <= StHalt;
      end else if ((r_state == StRun) && !(w_in_range && w_aligned)) begin
        r_state <= StHalt;
        r_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned ROM_BYTES = 4096;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (RESET_PC),
    .ROM_BYTES(ROM_BYTES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem [ROM_BYTES];
  int         mem_gen = 0;
  int         checks  = 0;
  int         errors  = 0;

  // Reference model: expected queue of delivered {pc, word} plus architectural pc/halt/fault.
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_fault;
  logic [31:0] q_pc[$];
  logic [31:0] q_word[$];

  function automatic bit legal(input logic [31:0] a);
    return (longint'(a) + 3 < longint'(ROM_BYTES)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (longint'(a) + 3 < longint'(ROM_BYTES))
      return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    return 32'h0;
  endfunction

  always @(bus.rom_addr, mem_gen) bus.rom_data = rom_word(bus.rom_addr);

  task automatic write_word(input logic [31:0] a, input logic [31:0] w);
    {mem[a], mem[a+1], mem[a+2], mem[a+3]} = w;
    mem_gen++;
  endtask

  task automatic fill_random(input bit with_ebreak);
    logic [31:0] w;
    for (int a = 0; a < int'(ROM_BYTES); a += 4) begin
      w = $urandom;
      if (w == EBREAK) w = w ^ 32'h1;
      if (with_ebreak && $urandom_range(0, 15) == 0) w = EBREAK;
      write_word(32'(a), w);
    end
  endtask

  function automatic bit m_rom_en();
    if (rst) return 1'b0;
    return !m_halted && legal(m_pc) &&
           (q_pc.size() < 2 || (q_pc.size() > 0 && bus.inst_ready));
  endfunction

  task automatic model_reset();
    q_pc.delete();
    q_word.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    bit push;
    pop  = (q_pc.size() > 0) && bus.inst_ready;
    push = m_rom_en();
    if (bus.redirect_valid) begin
      q_pc.delete();
      q_word.delete();
      m_pc     = bus.redirect_pc;
      m_halted = 1'b0;
      m_fault  = 1'b0;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_word.pop_front());
      end
      if (push) begin
        q_pc.push_back(m_pc);
        q_word.push_back(rom_word(m_pc));
        if (rom_word(m_pc) == EBREAK) m_halted = 1'b1;
        m_pc = m_pc + 32'd4;
      end else if (!m_halted && !legal(m_pc)) begin
        m_halted = 1'b1;
        m_fault  = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", bus.inst); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h exp 0", bus.inst_pc); end
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en got %b exp 0", bus.rom_en); end
    checks++; if (bus.rom_addr !== RESET_PC) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.rom_addr, RESET_PC); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", bus.fault); end
    rst = 1'b0;
    #1;
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL first_push got %b exp 1", bus.rom_en); end
  endtask

  task automatic test_sequential();
    for (int a = 0; a < 12; a += 4) write_word(32'(a), NOP);
    apply_reset();
    bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_fetch got en=%b addr=%h exp en=1 addr=0", bus.rom_en, bus.rom_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k) || bus.inst !== NOP) begin
        errors++; $display("FAIL seq_inst%0d got v=%b pc=%h w=%h exp v=1 pc=%h w=%h",
                           k, bus.inst_valid, bus.inst_pc, bus.inst, 32'(4 * k), NOP); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 0; k < 4; k++) tick();
    #1;
    checks++; if (bus.rom_en !== 1'b0) begin errors++; $display("FAIL bp_rom_en got %b exp 0", bus.rom_en); end
    checks++; if (bus.rom_addr !== 32'h8) begin errors++; $display("FAIL bp_pc got %h exp 8", bus.rom_addr); end
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
      errors++; $display("FAIL bp_hold got v=%b pc=%h exp v=1 pc=0", bus.inst_valid, bus.inst_pc); end
    bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL bp_full_push_pop got %b exp 1", bus.rom_en); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k) || bus.inst !== rom_word(32'(4 * k))) begin
        errors++; $display("FAIL bp_release%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.inst_valid, bus.inst_pc, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    apply_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", bus.inst_valid); end
    checks++; if (bus.rom_addr !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp 40", bus.rom_addr); end
    checks++; if (bus.rom_en !== 1'b1) begin errors++; $display("FAIL redir_fetch got %b exp 1", bus.rom_en); end
    tick();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=40", bus.inst_valid, bus.inst_pc); end
  endtask

  task automatic test_ebreak();
    for (int a = 0; a < 16; a += 4) write_word(32'(a), NOP);
    write_word(32'h10, EBREAK);
    apply_reset();
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL ebrk_deliver%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.inst_valid, bus.inst_pc, 32'(4 * k)); end
    end
    #1;
    checks++; if (bus.inst !== EBREAK) begin errors++; $display("FAIL ebrk_word got %h exp %h", bus.inst, EBREAK); end
    checks++; if (bus.halted !== 1'b1 || bus.fault !== 1'b0 || bus.rom_en !== 1'b0) begin
      errors++; $display("FAIL ebrk_halt got h=%b f=%b en=%b exp h=1 f=0 en=0", bus.halted, bus.fault, bus.rom_en); end
    tick();
    checks++; if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL ebrk_drain got v=%b h=%b exp v=0 h=1", bus.inst_valid, bus.halted); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 32'h0) begin
      errors++; $display("FAIL ebrk_resume got h=%b en=%b pc=%h exp h=0 en=1 pc=0", bus.halted, bus.rom_en, bus.rom_addr); end
    write_word(32'h10, NOP);
  endtask

  task automatic test_fault();
    logic [31:0] targets [2];
    targets[0] = 32'h102;
    targets[1] = 32'(ROM_BYTES);
    apply_reset();
    bus.inst_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = targets[t];
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      checks++; if (bus.rom_en !== 1'b0 || bus.halted !== 1'b0 || bus.rom_addr !== targets[t]) begin
        errors++; $display("FAIL fault_nopush%0d got en=%b h=%b pc=%h exp en=0 h=0 pc=%h",
                           t, bus.rom_en, bus.halted, bus.rom_addr, targets[t]); end
      tick();
      checks++; if (bus.halted !== 1'b1 || bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin
        errors++; $display("FAIL fault_halt%0d got h=%b f=%b v=%b exp h=1 f=1 v=0", t, bus.halted, bus.fault, bus.inst_valid); end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'(ROM_BYTES - 4);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.fault !== 1'b0 || bus.rom_en !== 1'b1) begin
      errors++; $display("FAIL last_word_fetch got f=%b en=%b exp f=0 en=1", bus.fault, bus.rom_en); end
    tick();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(ROM_BYTES - 4) || bus.halted !== 1'b0) begin
      errors++; $display("FAIL last_word_deliver got v=%b pc=%h h=%b exp v=1 pc=%h h=0",
                         bus.inst_valid, bus.inst_pc, bus.halted, 32'(ROM_BYTES - 4)); end
    tick();
    checks++; if (bus.halted !== 1'b1 || bus.fault !== 1'b1) begin
      errors++; $display("FAIL end_of_rom got h=%b f=%b exp h=1 f=1", bus.halted, bus.fault); end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset got v=%b w=%h pc=%h exp v=0 w=0 pc=0", bus.inst_valid, bus.inst, bus.inst_pc); end
    apply_reset();
    checks++; if (bus.inst_valid !== 1'b0 || bus.rom_addr !== RESET_PC) begin
      errors++; $display("FAIL post_reset got v=%b pc=%h exp v=0 pc=%h", bus.inst_valid, bus.rom_addr, RESET_PC); end
  endtask

  task automatic test_random();
    int bad;
    fill_random(1'b1);
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, m_halted ? 3 : 24) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: bus.redirect_pc = 32'($urandom_range(0, ROM_BYTES / 4 - 1)) << 2;
        3:       bus.redirect_pc = 32'(ROM_BYTES - 4 * $urandom_range(1, 3));
        4:       bus.redirect_pc = (32'($urandom_range(0, ROM_BYTES / 4 - 1)) << 2) | 32'($urandom_range(1, 3));
        default: bus.redirect_pc = $urandom | 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rnd_reset cyc %0d got v=%b exp 0", cyc, bus.inst_valid); end
        apply_reset();
        continue;
      end
      #1;
      bad = 0;
      if (bus.inst_valid !== (q_pc.size() > 0)) bad = 1;
      if (q_pc.size() > 0 && (bus.inst_pc !== q_pc[0] || bus.inst !== q_word[0])) bad = 1;
      if (bus.rom_en !== m_rom_en() || bus.rom_addr !== m_pc) bad = 1;
      if (bus.halted !== m_halted || bus.fault !== m_fault) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd cyc %0d got v=%b pc=%h w=%h en=%b addr=%h h=%b f=%b exp v=%b pc=%h w=%h en=%b addr=%h h=%b f=%b",
                 cyc, bus.inst_valid, bus.inst_pc, bus.inst, bus.rom_en, bus.rom_addr, bus.halted, bus.fault,
                 q_pc.size() > 0, (q_pc.size() > 0) ? q_pc[0] : 32'h0, (q_word.size() > 0) ? q_word[0] : 32'h0,
                 m_rom_en(), m_pc, m_halted, m_fault);
      end
      tick();
    end
  endtask

  initial begin
    fill_random(1'b0);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_ebreak();
    test_fault();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter ROM_BYTES, default 4096, the instruction ROM size in bytes; the legal fetch range is pc+3 < ROM_BYTES.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rom_addr, output, 32: byte address to the ROM, always equal to pc.
REQ-006 SHALL have port rom_en, output, 1: ROM read enable.
REQ-007 SHALL have port rom_data, input, 32: ROM word, combinational from rom_addr, big-endian byte order (mem[addr] = bits 31:24).
REQ-008 SHALL have port redirect_valid, input, 1: branch or jump taken; load the new pc.
REQ-009 SHALL have port redirect_pc, input, 32: the redirect target.
REQ-010 SHALL have port inst_valid, output, 1: the FIFO head holds an instruction.
REQ-011 SHALL have port inst_ready, input, 1: decode accepts the head this cycle.
REQ-012 SHALL have port inst, output, 32: the head instruction word.
REQ-013 SHALL have port inst_pc, output, 32: the head instruction's address.
REQ-014 SHALL have port halted, output, 1: fetch is stopped in HALT.
REQ-015 SHALL have port fault, output, 1: HALT was entered by an out-of-range or misaligned pc.

Function
REQ-016 SHALL hold a 32-bit pc and a 2-entry FIFO of {pc, word} pairs; the FIFO outputs are registered.
REQ-017 SHALL implement states RUN and HALT.
REQ-018 SHALL define push = (state == RUN) && in_range(pc) && pc[1:0] == 0 && (count < 2 || pop).
REQ-019 SHALL define pop = inst_valid && inst_ready.
REQ-020 SHALL drive rom_en = push.
REQ-021 On push, SHALL write {pc, rom_data} to the FIFO tail and set pc <= pc + 4, wrapping modulo 2^32.
REQ-022 SHALL allow push and pop in the same cycle when the FIFO is full; count is then unchanged and order is preserved.
REQ-023 SHALL drive inst_valid = (count != 0); inst and inst_pc SHALL be stable while inst_valid && !inst_ready.
REQ-024 SHALL keep rom_en = 0 and pc unchanged when the FIFO is full and there is no pop.
REQ-025 RUN -> HALT: when the pushed word equals 32'h0010_0073 (ebreak), the word is still enqueued and fault stays 0.
REQ-026 RUN -> HALT: when pc is out of range or pc[1:0] != 0, nothing is pushed and fault is set to 1.
REQ-027 In HALT, the FIFO SHALL continue to drain normally via pop.
REQ-028 redirect_valid (any state) SHALL, at the next edge: flush the FIFO (count <= 0), set pc <= redirect_pc, enter RUN, and clear fault.
REQ-029 redirect_valid SHALL take priority over push and pop in the same cycle; the push is discarded and the pop has no effect.
REQ-030 SHALL drive halted = (state == HALT).
REQ-031 SHALL give one cycle of latency: a word fetched in cycle N appears on inst in cycle N+1.
REQ-032 SHALL sustain a throughput of 1 instruction per cycle while inst_ready is held at 1.

Reset
REQ-033 While rst = 1, asynchronously: pc = RESET_PC, count = 0, state = RUN, fault = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-034 rom_en SHALL be 0 during reset; the first push occurs in the first cycle after rst deasserts.
REQ-035 rst asserted mid-stream SHALL discard all FIFO contents; no stale inst_valid may appear after reset.

Verification
REQ-036 ROM words 0x00000013 at 0, 4, 8 with inst_ready = 1 -> inst_pc sequence 0, 4, 8 on consecutive cycles, 1 cycle after reset.
REQ-037 inst_ready = 0 for 4 cycles -> count saturates at 2, rom_en = 0, pc = 8, inst_pc stays 0; after release -> 0, 4, 8 with no loss or duplication.
REQ-038 redirect_valid with redirect_pc = 0x40 while the FIFO is full -> next cycle inst_valid = 0, pc = 0x40; then inst_pc = 0x40 follows.
REQ-039 ebreak at 0x10 -> instructions 0x00 through 0x10 are delivered, then halted = 1, fault = 0, rom_en = 0; redirect to 0 resumes fetch.
REQ-040 redirect to 0x102 or to ROM_BYTES -> halted = 1, fault = 1, no push occurs; rst asserted mid-stream -> inst_valid = 0 immediately.
